alu: RTL and testbench
======================

// Module: alu
//
// PURPOSE
//   64-bit datapath ALU for the single-cycle processor datapath. Combinationally
//   computes BusW = f(BusA, BusB) for the operation selected by ALUCtrl, plus a
//   combinational Zero flag used by the branch logic (CBZ/CBNZ).
//   Also keeps an NZCV condition-flag register, loaded on the clock when FlagEn
//   is asserted (flag-setting instructions such as ADDS/SUBS).
//
// PARAMETERS
//   WIDTH    64   datapath width in bits; all arithmetic is modulo 2^WIDTH
//
// PORTS
//   CLK      in   1      system clock; flag register updates on the rising edge
//   RESETn   in   1      asynchronous active-low reset; clears the flag register
//   BusA     in   WIDTH  operand A
//   BusB     in   WIDTH  operand B; also the pass-through source and shift amount
//   ALUCtrl  in   4      operation select (encoding below)
//   FlagEn   in   1      1 = load NZCV from the current result at the next CLK edge
//   BusW     out  WIDTH  result (combinational)
//   Zero     out  1      1 when BusW == 0 (combinational)
//   Flags    out  4      registered {N,Z,C,V}
//
// BEHAVIOUR
//   - BusW and Zero are purely combinational, independent of CLK and RESETn.
//     They settle within one cycle of any input change; there is no latency and
//     no handshake.
//   - ALUCtrl encoding:
//       4'h0 AND  : BusA & BusB
//       4'h1 ORR  : BusA | BusB
//       4'h2 ADD  : BusA + BusB
//       4'h3 EOR  : BusA ^ BusB
//       4'h4 LSL  : BusA << BusB[5:0]
//       4'h5 LSR  : BusA >> BusB[5:0] (logical, zero fill)
//       4'h6 SUB  : BusA - BusB, computed as BusA + ~BusB + 1
//       4'h7 PASSB: BusB
//       all other codes: BusW = 0, so Zero = 1
//   - ADD/SUB wrap modulo 2^64; carry-out is not part of BusW.
//   - Zero = ~|BusW for every opcode, including logical ops and PASSB.
//   - Next-flag values, derived from the current combinational result:
//       N = BusW[63]
//       Z = Zero
//       C = carry-out of bit 63 for ADD/SUB (SUB: C=1 means no borrow); 0 for
//           all other ops
//       V = signed overflow for ADD/SUB:
//             ADD: A[63]==B[63] && W[63]!=A[63]
//             SUB: A[63]!=B[63] && W[63]!=A[63]
//           0 for all other ops
//   - Flags register: on RESETn low, Flags = 4'b0000 immediately, asynchronously.
//     On a rising CLK edge with RESETn high, FlagEn=1 loads the next-flag
//     values; FlagEn=0 holds the register.
//   - If RESETn is low while FlagEn is high, reset wins. Flags stay 0 until the
//     first edge after RESETn deasserts.
//   - Flags never feeds back into the BusW computation (no add-with-carry).
//
// TESTING
//   1. ADD: BusA=0x1234, BusB=0xABCD0000, ALUCtrl=2 -> BusW=0xABCD1234, Zero=0.
//   2. AND: 0x100 & 0x20 -> BusW=0, Zero=1. AND: 0x20 & 0x20 -> BusW=0x20, Zero=0.
//   3. ORR: 0x11 | 0x10 -> BusW=0x11. ORR: 0x35 | 0x25 -> BusW=0x35.
//   4. SUB: 0x10-0x10 -> BusW=0, Zero=1. SUB: 0x90-0x10 -> 0x80.
//      SUB: 0x80-0x20 -> 0x60.
//   5. PASSB: BusA=0x3, BusB=0x10, ALUCtrl=7 -> BusW=0x10, Zero=0.
//      ALUCtrl=0xF with any inputs -> BusW=0, Zero=1.
//   6. Flags: SUB 0x0-0x1 with FlagEn=1, then one CLK edge -> Flags=4'b1000
//      (N=1, C=0). Pulse RESETn low mid-cycle -> Flags=0 immediately.
//      ADD 0x7FFF_FFFF_FFFF_FFFF+1 with FlagEn=1 -> Flags=4'b1001.
//   Apply combinational checks 40 ns after each input change.

Source files
------------

// File: rtl/alu.sv
// 64-bit datapath ALU: combinational result and Zero flag, plus an NZCV
// condition-flag register loaded on the clock when FlagEn is asserted.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  input  logic             FlagEn,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic [3:0]       Flags
);

  // Shift amount is taken from the low bits of BusB (6 bits for 64-bit data).
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND   = 4'h0,
    OP_ORR   = 4'h1,
    OP_ADD   = 4'h2,
    OP_EOR   = 4'h3,
    OP_LSL   = 4'h4,
    OP_LSR   = 4'h5,
    OP_SUB   = 4'h6,
    OP_PASSB = 4'h7
  } alu_op_e;

  logic             is_sub_s;
  logic             is_arith_s;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH:0]   sum_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] result_s;
  logic             zero_s;
  logic             carry_s;
  logic             ovf_s;
  logic [3:0]       next_flags_s;
  logic [3:0]       flags_r;

  // Shared adder: SUB reuses the ADD path as A + ~B + 1, so the carry out of
  // the top bit is directly the "no borrow" C flag.
  always_comb begin
    is_sub_s   = 1'b0;
    is_arith_s = 1'b0;
    if (ALUCtrl == OP_SUB) begin
      is_sub_s   = 1'b1;
      is_arith_s = 1'b1;
    end else if (ALUCtrl == OP_ADD) begin
      is_sub_s   = 1'b0;
      is_arith_s = 1'b1;
    end else begin
      is_sub_s   = 1'b0;
      is_arith_s = 1'b0;
    end
    if (is_sub_s) begin
      addend_s = ~BusB;
    end else begin
      addend_s = BusB;
    end
    sum_s = {1'b0, BusA} + {1'b0, addend_s} + {{WIDTH{1'b0}}, is_sub_s};
  end

  // Result multiplexer; unused opcodes deliberately yield zero.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    shamt_s  = BusB[SHW-1:0];
    case (ALUCtrl)
      OP_AND:   result_s = BusA & BusB;
      OP_ORR:   result_s = BusA | BusB;
      OP_ADD:   result_s = sum_s[WIDTH-1:0];
      OP_EOR:   result_s = BusA ^ BusB;
      OP_LSL:   result_s = BusA << shamt_s;
      OP_LSR:   result_s = BusA >> shamt_s;
      OP_SUB:   result_s = sum_s[WIDTH-1:0];
      OP_PASSB: result_s = BusB;
      default:  result_s = {WIDTH{1'b0}};
    endcase
  end

  // Next NZCV values; C and V only carry meaning for ADD/SUB.
  always_comb begin
    zero_s = ~|result_s;
    if (is_arith_s) begin
      carry_s = sum_s[WIDTH];
      // Overflow when both adder inputs share a sign that the result lacks;
      // for SUB the adder input is ~B, which covers the A/B sign-differ case.
      ovf_s   = (BusA[WIDTH-1] == addend_s[WIDTH-1]) &&
                (result_s[WIDTH-1] != BusA[WIDTH-1]);
    end else begin
      carry_s = 1'b0;
      ovf_s   = 1'b0;
    end
    next_flags_s = {result_s[WIDTH-1], zero_s, carry_s, ovf_s};
  end

  // Condition-flag register: asynchronous clear, load only when FlagEn is set.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      flags_r <= 4'b0000;
    end else if (FlagEn) begin
      flags_r <= next_flags_s;
    end else begin
      flags_r <= flags_r;
    end
  end

  assign BusW  = result_s;
  assign Zero  = zero_s;
  assign Flags = flags_r;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed spec cases, flag/reset behaviour, and
// randomized operations checked against an arithmetic reference model.
module tb_alu;

  logic        CLK;
  logic        RESETn;
  logic [63:0] BusA;
  logic [63:0] BusB;
  logic [3:0]  ALUCtrl;
  logic        FlagEn;
  logic [63:0] BusW;
  logic        Zero;
  logic [3:0]  Flags;

  int n_cmp;
  int n_bad;

  localparam logic signed [64:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] SMIN = 65'sh1_8000_0000_0000_0000;

  alu #(.WIDTH(64)) dut (
    .CLK(CLK), .RESETn(RESETn), .BusA(BusA), .BusB(BusB),
    .ALUCtrl(ALUCtrl), .FlagEn(FlagEn), .BusW(BusW), .Zero(Zero), .Flags(Flags)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference result from the operation table.
  function automatic logic [63:0] ref_w(logic [63:0] a, logic [63:0] b, logic [3:0] op);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h3: return a ^ b;
      4'h4: return a << b[5:0];
      4'h5: return a >> b[5:0];
      4'h6: return a - b;
      4'h7: return b;
      default: return 64'h0;
    endcase
  endfunction

  // Reference NZCV using wide signed/unsigned arithmetic.
  function automatic logic [3:0] ref_flags(logic [63:0] a, logic [63:0] b, logic [3:0] op);
    logic [63:0] w;
    logic [64:0] u;
    logic signed [64:0] s;
    logic c, v;
    w = ref_w(a, b, op);
    c = 1'b0;
    v = 1'b0;
    if (op == 4'h2) begin
      u = {1'b0, a} + {1'b0, b};
      c = u[64];
      s = $signed({a[63], a}) + $signed({b[63], b});
      v = (s > SMAX) || (s < SMIN);
    end else if (op == 4'h6) begin
      c = (a >= b);
      s = $signed({a[63], a}) - $signed({b[63], b});
      v = (s > SMAX) || (s < SMIN);
    end
    return {w[63], (w == 64'h0), c, v};
  endfunction

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply operands at a negedge and check the combinational outputs 40 ns later.
  task automatic comb(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] op, input logic [63:0] exp_w, input logic exp_z);
    BusA = a; BusB = b; ALUCtrl = op; FlagEn = 1'b0;
    #40;
    chk64({tag, "_w"}, BusW, exp_w);
    chk4({tag, "_z"}, {3'b000, Zero}, {3'b000, exp_z});
  endtask

  // Load flags for one edge from the given operation and check them.
  task automatic flag_load(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] op, input logic [3:0] exp_f);
    BusA = a; BusB = b; ALUCtrl = op; FlagEn = 1'b1;
    @(posedge CLK);
    #1;
    FlagEn = 1'b0;
    chk4(tag, Flags, exp_f);
    @(negedge CLK);
  endtask

  initial begin
    logic [63:0] a, b, ew;
    logic [3:0]  op, ef, held;
    n_cmp = 0;
    n_bad = 0;
    RESETn = 1'b0; FlagEn = 1'b0; BusA = 64'h0; BusB = 64'h0; ALUCtrl = 4'h0;

    // Reset state, and reset wins over FlagEn across a clock edge.
    #3;
    chk4("reset_flags", Flags, 4'b0000);
    BusA = 64'h0; BusB = 64'h1; ALUCtrl = 4'h6; FlagEn = 1'b1;
    @(posedge CLK);
    #1;
    chk4("reset_beats_flagen", Flags, 4'b0000);
    @(negedge CLK);
    RESETn = 1'b1; FlagEn = 1'b0;

    // Directed combinational cases.
    comb("add",     64'h1234, 64'hABCD0000, 4'h2, 64'hABCD1234, 1'b0);
    comb("and0",    64'h100,  64'h20,       4'h0, 64'h0,        1'b1);
    comb("and1",    64'h20,   64'h20,       4'h0, 64'h20,       1'b0);
    comb("orr0",    64'h11,   64'h10,       4'h1, 64'h11,       1'b0);
    comb("orr1",    64'h35,   64'h25,       4'h1, 64'h35,       1'b0);
    comb("sub0",    64'h10,   64'h10,       4'h6, 64'h0,        1'b1);
    comb("sub1",    64'h90,   64'h10,       4'h6, 64'h80,       1'b0);
    comb("sub2",    64'h80,   64'h20,       4'h6, 64'h60,       1'b0);
    comb("passb",   64'h3,    64'h10,       4'h7, 64'h10,       1'b0);
    comb("undef_f", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 4'hF, 64'h0, 1'b1);
    comb("eor",     64'hF0F0, 64'hFF00,     4'h3, 64'h0FF0,     1'b0);
    comb("lsl63",   64'h3,    64'h7F,       4'h4, 64'h8000_0000_0000_0000, 1'b0);
    comb("lsr63",   64'h8000_0000_0000_0001, 64'h3F, 4'h5, 64'h1, 1'b0);
    comb("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'h2, 64'h0, 1'b1);

    // Flag register: load, hold, async clear, overflow case.
    flag_load("flags_sub_0m1", 64'h0, 64'h1, 4'h6, 4'b1000);
    BusA = 64'h5; BusB = 64'h5; ALUCtrl = 4'h6; FlagEn = 1'b0;
    @(posedge CLK);
    #1;
    chk4("flags_hold", Flags, 4'b1000);
    @(negedge CLK);
    #2 RESETn = 1'b0;
    #1 chk4("flags_async_clear", Flags, 4'b0000);
    #1 RESETn = 1'b1;
    @(negedge CLK);
    chk4("flags_after_reset", Flags, 4'b0000);
    flag_load("flags_add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'h2, 4'b1001);
    flag_load("flags_sub_eq", 64'h10, 64'h10, 4'h6, 4'b0110);
    flag_load("flags_logic", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 4'b1000);

    // Randomized operations against the reference model.
    for (int i = 0; i < 80; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0: b = a;
        1: a = {1'b0, a[62:0]} | 64'h7FFF_FFFF_0000_0000;
        2: b = 64'($urandom_range(0, 70));
        default: ;
      endcase
      ew = ref_w(a, b, op);
      ef = ref_flags(a, b, op);
      comb($sformatf("rnd%0d_op%0h", i, op), a, b, op, ew, (ew == 64'h0));
      if (i % 4 == 3) begin
        held = Flags;
        FlagEn = 1'b0;
        @(posedge CLK);
        #1;
        chk4($sformatf("rnd%0d_hold", i), Flags, held);
        @(negedge CLK);
      end else begin
        flag_load($sformatf("rnd%0d_flags_op%0h", i, op), a, b, op, ef);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
